viterbi_acs_unit: RTL and testbench
===================================

Name: viterbi_acs_unit

Overview:
Add-compare-select stage for the rate-1/2, K=3 (4-state) Viterbi decoder. It sits directly downstream of the branch-metric units. Each trellis step it consumes the eight 2-bit branch metrics, updates four registered path metrics, and emits one survivor decision bit per state to the traceback memory. It also reports the current best state and flags metric normalization.

Parameters:
PM_W, 8, path-metric width in bits; legal range 6..16.
INIT_PM, 32, initial metric for states 1..3 at reset and at frame start; state 0 always starts at 0. Must satisfy INIT_PM <= 2^(PM_W-2).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
frame_start  input  1  re-initialise path metrics
bm_valid  input  1  bm_bus holds one trellis step
bm_bus  input  16  branch metrics; metric for next-state s, predecessor branch b in bits [4s+2b+1 : 4s+2b]
surv_valid  output  1  surv_bits/best_state valid this cycle
surv_bits  output  4  bit s = LSB of winning predecessor of state s
best_state  output  2  state with minimum updated metric
norm_event  output  1  normalization applied on this update
pm_out  output  4*PM_W  registered path metrics; state s in bits [PM_W*(s+1)-1 : PM_W*s]
step_cnt  output  16  trellis steps accepted since reset or frame_start

Behaviour:
- Reset (asynchronous, active-high):
  - pm[0]=0; pm[1..3]=INIT_PM.
  - surv_valid=0, surv_bits=0, best_state=0, norm_event=0, step_cnt=0.
- Trellis definition:
  - Next state s' = {u, s[1]}.
  - Predecessors of s' are p0 = {s'[0],0} (branch b=0) and p1 = {s'[0],1} (branch b=1).
- Update on a cycle with bm_valid=1:
  - cand_b = pm[p_b] + bm[s'][b], computed in PM_W+1 bits.
  - Winner = smaller candidate. Tie selects b=0.
  - surv_bits[s'] = b of the winner.
  - New metric = winning candidate (truncated to PM_W bits).
- Normalization (same cycle, before registering):
  - Triggers when all four new metrics have bit PM_W-1 set.
  - Action: clear that bit in all four metrics and pulse norm_event=1.
  - Given the INIT_PM constraint, candidates never overflow PM_W bits.
- best_state: lowest index among the minimum post-normalization metrics.
- Latency: surv_valid, surv_bits, best_state, norm_event, pm_out and step_cnt update on the clock edge after bm_valid is sampled (1 cycle).
- surv_valid and norm_event are single-cycle pulses. When bm_valid=0:
  - surv_valid=0 and norm_event=0.
  - surv_bits, best_state and pm hold their values.
- frame_start=1 with bm_valid=0: next edge loads the init metrics, clears step_cnt, surv_valid=0.
- frame_start=1 with bm_valid=1: the step uses the init metrics instead of the registered pm, step_cnt becomes 1, surv_valid=1.
- step_cnt increments once per accepted step and wraps from 0xFFFF to 0.
- bm values of 3 are legal and used unmodified.
- Reset asserted mid-stream overrides everything immediately. The first bm_valid after release is processed against the reset metrics.
- No backpressure. Every bm_valid step is accepted; back-to-back steps sustain one per cycle.

Test Plan:
- Reset, then one step with bm_bus=0x0000 -> pm_out states 0..3 = {0,32,0,32}, surv_bits=0000, best_state=0, surv_valid pulses once, step_cnt=1.
- INIT_PM=0, step with every b=0 metric=2 and every b=1 metric=1 (bm_bus=0x6666) -> all pm=1, surv_bits=1111, best_state=0.
- INIT_PM=0, 64 consecutive steps with bm_bus=0xAAAA -> step 63 gives all pm=126, norm_event=0; step 64 gives all pm=0, norm_event=1 for exactly one cycle; step_cnt=64.
- After 5 steps of stream, pulse frame_start alone -> pm returns to {0,32,0,32}, step_cnt=0, surv_valid stays 0; then frame_start+bm_valid with 0x0000 -> step_cnt=1, pm={0,32,0,32}.
- bm_valid gaps (valid 1,0,0,1) -> surv_valid pulses only on cycles following valid steps; outputs hold during gaps.
- Assert rst between two back-to-back valid steps -> outputs return to reset values asynchronously; next step after release matches the first scenario's result.

Source files
------------

// File: rtl/viterbi_acs_unit.sv
// Add-compare-select stage for a rate-1/2, K=3 (4-state) Viterbi decoder.
// Updates four path metrics per trellis step and emits survivor decisions, best state and norm flag.
module viterbi_acs_unit #(
    parameter int unsigned PM_W    = 8,
    parameter int unsigned INIT_PM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              bm_valid,
    input  logic [15:0]       bm_bus,
    output logic              surv_valid,
    output logic [3:0]        surv_bits,
    output logic [1:0]        best_state,
    output logic              norm_event,
    output logic [4*PM_W-1:0] pm_out,
    output logic [15:0]       step_cnt
);

    localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

    logic [PM_W-1:0] r_pm [4];
    logic            r_surv_valid;
    logic [3:0]      r_surv_bits;
    logic [1:0]      r_best_state;
    logic            r_norm_event;
    logic [15:0]     r_step_cnt;

    logic [PM_W-1:0] w_base [4];
    logic [PM_W:0]   w_cand0 [4];
    logic [PM_W:0]   w_cand1 [4];
    logic [PM_W-1:0] w_new [4];
    logic [PM_W-1:0] w_post [4];
    logic [3:0]      w_sel;
    logic            w_norm;
    logic [1:0]      w_best;

    assign w_norm = w_new[0][PM_W-1] & w_new[1][PM_W-1] & w_new[2][PM_W-1] & w_new[3][PM_W-1];

    for (genvar g = 0; g < 4; g++) begin : g_state
        localparam int unsigned P0 = 2 * (g % 2);
        localparam logic [PM_W-1:0] INIT_G = (g == 0) ? {PM_W{1'b0}} : INIT_V;

        // A step coinciding with frame_start runs against the init metrics.
        assign w_base[g]  = frame_start ? INIT_G : r_pm[g];
        assign w_cand0[g] = {1'b0, w_base[P0]} + {{(PM_W - 1){1'b0}}, bm_bus[4*g +: 2]};
        assign w_cand1[g] = {1'b0, w_base[P0+1]} + {{(PM_W - 1){1'b0}}, bm_bus[4*g+2 +: 2]};
        assign w_sel[g]   = (w_cand1[g] < w_cand0[g]);
        assign w_new[g]   = w_sel[g] ? w_cand1[g][PM_W-1:0] : w_cand0[g][PM_W-1:0];
        assign w_post[g]  = w_norm ? {1'b0, w_new[g][PM_W-2:0]} : w_new[g];
        assign pm_out[PM_W*g +: PM_W] = r_pm[g];
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        w_best = 2'd0;
        for (int s = 1; s < 4; s++) begin
            if (w_post[s] < w_post[w_best]) begin
                w_best = 2'(s);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pm[0]      <= '0;
            r_pm[1]      <= INIT_V;
            r_pm[2]      <= INIT_V;
            r_pm[3]      <= INIT_V;
            r_surv_valid <= 1'b0;
            r_surv_bits  <= 4'd0;
            r_best_state <= 2'd0;
            r_norm_event <= 1'b0;
            r_step_cnt   <= 16'd0;
        end else begin
            r_surv_valid <= bm_valid;
            r_norm_event <= bm_valid & w_norm;
            if (bm_valid) begin
                for (int s = 0; s < 4; s++) begin
                    r_pm[s] <= w_post[s];
                end
                r_surv_bits  <= w_sel;
                r_best_state <= w_best;
                r_step_cnt   <= frame_start ? 16'd1 : r_step_cnt + 16'd1;
            end else if (frame_start) begin
                r_pm[0]    <= '0;
                r_pm[1]    <= INIT_V;
                r_pm[2]    <= INIT_V;
                r_pm[3]    <= INIT_V;
                r_step_cnt <= 16'd0;
            end
        end
    end

    assign surv_valid = r_surv_valid;
    assign surv_bits  = r_surv_bits;
    assign best_state = r_best_state;
    assign norm_event = r_norm_event;
    assign step_cnt   = r_step_cnt;

endmodule

// File: tb/tb_viterbi_acs_unit.sv
// Self-checking bench for viterbi_acs_unit: two instances (INIT_PM=32 and INIT_PM=0) share stimulus
// and are compared every cycle against a behavioural trellis model, plus directed vectors.
module tb_viterbi_acs_unit;

    localparam int PM_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        bm_valid;
    logic [15:0] bm_bus;

    logic        sv_a, sv_b;
    logic [3:0]  sb_a, sb_b;
    logic [1:0]  bs_a, bs_b;
    logic        ne_a, ne_b;
    logic [31:0] pm_a, pm_b;
    logic [15:0] sc_a, sc_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    viterbi_acs_unit #(.PM_W(PM_W), .INIT_PM(32)) u_dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bm_valid(bm_valid), .bm_bus(bm_bus),
        .surv_valid(sv_a), .surv_bits(sb_a), .best_state(bs_a), .norm_event(ne_a),
        .pm_out(pm_a), .step_cnt(sc_a)
    );

    viterbi_acs_unit #(.PM_W(PM_W), .INIT_PM(0)) u_dut0 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bm_valid(bm_valid), .bm_bus(bm_bus),
        .surv_valid(sv_b), .surv_bits(sb_b), .best_state(bs_b), .norm_event(ne_b),
        .pm_out(pm_b), .step_cnt(sc_b)
    );

    // Reference model: index 0 models u_dut, index 1 models u_dut0.
    int          minit [2] = '{32, 0};
    int          mpm   [2][4];
    logic [3:0]  msurv [2];
    logic [1:0]  mbest [2];
    logic        mnorm [2];
    logic        msv;
    logic [15:0] mcnt;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mpm[k][0] = 0;
            for (int s = 1; s < 4; s++) mpm[k][s] = minit[k];
            msurv[k] = 4'd0;
            mbest[k] = 2'd0;
            mnorm[k] = 1'b0;
        end
        msv  = 1'b0;
        mcnt = 16'd0;
    endtask

    task automatic model_step(input logic v, input logic fs, input logic [15:0] bm);
        int base [4];
        int nw   [4];
        int c0, c1, p0;
        logic [3:0] sel;
        logic all_hi;
        msv = v;
        for (int k = 0; k < 2; k++) begin
            mnorm[k] = 1'b0;
            if (v) begin
                for (int s = 0; s < 4; s++) base[s] = fs ? ((s == 0) ? 0 : minit[k]) : mpm[k][s];
                for (int s = 0; s < 4; s++) begin
                    p0 = 2 * (s % 2);
                    c0 = base[p0] + int'((bm >> (4 * s)) & 16'h3);
                    c1 = base[p0 + 1] + int'((bm >> (4 * s + 2)) & 16'h3);
                    sel[s] = (c1 < c0);
                    nw[s]  = ((c1 < c0) ? c1 : c0) % (1 << PM_W);
                end
                all_hi = 1'b1;
                for (int s = 0; s < 4; s++) if (nw[s] < (1 << (PM_W - 1))) all_hi = 1'b0;
                if (all_hi) for (int s = 0; s < 4; s++) nw[s] -= (1 << (PM_W - 1));
                mnorm[k] = all_hi;
                msurv[k] = sel;
                mbest[k] = 2'd0;
                for (int s = 3; s >= 0; s--) begin
                    if (nw[s] <= nw[mbest[k]]) mbest[k] = 2'(s);
                end
                for (int s = 0; s < 4; s++) mpm[k][s] = nw[s];
            end else if (fs) begin
                mpm[k][0] = 0;
                for (int s = 1; s < 4; s++) mpm[k][s] = minit[k];
            end
        end
        if (v) mcnt = fs ? 16'd1 : mcnt + 16'd1;
        else if (fs) mcnt = 16'd0;
    endtask

    function automatic logic [31:0] pack_pm(input int k);
        logic [31:0] r;
        for (int s = 0; s < 4; s++) r[8*s +: 8] = 8'(mpm[k][s]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a.surv_valid", 64'(sv_a), 64'(msv));
        chk("a.surv_bits",  64'(sb_a), 64'(msurv[0]));
        chk("a.best_state", 64'(bs_a), 64'(mbest[0]));
        chk("a.norm_event", 64'(ne_a), 64'(mnorm[0]));
        chk("a.pm_out",     64'(pm_a), 64'(pack_pm(0)));
        chk("a.step_cnt",   64'(sc_a), 64'(mcnt));
        chk("b.surv_valid", 64'(sv_b), 64'(msv));
        chk("b.surv_bits",  64'(sb_b), 64'(msurv[1]));
        chk("b.best_state", 64'(bs_b), 64'(mbest[1]));
        chk("b.norm_event", 64'(ne_b), 64'(mnorm[1]));
        chk("b.pm_out",     64'(pm_b), 64'(pack_pm(1)));
        chk("b.step_cnt",   64'(sc_b), 64'(mcnt));
    endtask

    task automatic cyc(input logic v, input logic fs, input logic [15:0] bm);
        @(negedge clk);
        bm_valid    = v;
        frame_start = fs;
        bm_bus      = bm;
        @(posedge clk);
        model_step(v, fs, bm);
        #1;
        check_all();
    endtask

    typedef struct {
        logic        v;
        logic [15:0] bm;
        logic [31:0] pm;
        logic [3:0]  surv;
        logic [1:0]  best;
    } vec_t;

    vec_t tbl [8];

    initial begin
        // Expected pm packed as {pm3,pm2,pm1,pm0}, for the INIT_PM=32 instance from reset.
        tbl[0] = '{1'b1, 16'h0000, {8'd32, 8'd0, 8'd32, 8'd0}, 4'b0000, 2'd0};
        tbl[1] = '{1'b1, 16'h6666, {8'd2,  8'd2, 8'd2,  8'd2}, 4'b0000, 2'd0};
        tbl[2] = '{1'b1, 16'hFFFF, {8'd5,  8'd5, 8'd5,  8'd5}, 4'b0000, 2'd0};
        tbl[3] = '{1'b0, 16'h1234, {8'd5,  8'd5, 8'd5,  8'd5}, 4'b0000, 2'd0};
        tbl[4] = '{1'b1, 16'h0003, {8'd5,  8'd5, 8'd5,  8'd5}, 4'b0001, 2'd0};
        tbl[5] = '{1'b1, 16'h1234, {8'd5,  8'd5, 8'd5,  8'd5}, 4'b1110, 2'd0};
        tbl[6] = '{1'b1, 16'h5545, {8'd6,  8'd6, 8'd5,  8'd6}, 4'b0000, 2'd1};
        tbl[7] = '{1'b1, 16'h0000, {8'd6,  8'd5, 8'd6,  8'd5}, 4'b0101, 2'd0};

        rst = 1'b1; frame_start = 1'b0; bm_valid = 1'b0; bm_bus = 16'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].v, 1'b0, tbl[i].bm);
            chk($sformatf("tbl%0d.pm", i),   64'(pm_a), 64'(tbl[i].pm));
            chk($sformatf("tbl%0d.surv", i), 64'(sb_a), 64'(tbl[i].surv));
            chk($sformatf("tbl%0d.best", i), 64'(bs_a), 64'(tbl[i].best));
            chk($sformatf("tbl%0d.sv", i),   64'(sv_a), 64'(tbl[i].v));
        end

        // INIT_PM=0: one step of 0x6666 from init metrics
        cyc(1'b0, 1'b1, 16'h0);
        cyc(1'b1, 1'b0, 16'h6666);
        chk("z6666.pm",   64'(pm_b), 64'h01010101);
        chk("z6666.surv", 64'(sb_b), 64'hF);
        chk("z6666.best", 64'(bs_b), 64'h0);

        // INIT_PM=0: 64 steps of 0xAAAA, normalization on step 64
        cyc(1'b0, 1'b1, 16'h0);
        for (int i = 1; i <= 64; i++) begin
            cyc(1'b1, 1'b0, 16'hAAAA);
            if (i == 63) begin
                chk("norm63.pm",   64'(pm_b), {32'd0, {4{8'd126}}});
                chk("norm63.norm", 64'(ne_b), 64'h0);
            end
        end
        chk("norm64.pm",   64'(pm_b), 64'h0);
        chk("norm64.norm", 64'(ne_b), 64'h1);
        chk("norm64.cnt",  64'(sc_b), 64'd64);
        cyc(1'b0, 1'b0, 16'h0);
        chk("norm65.norm", 64'(ne_b), 64'h0);

        // frame_start alone after 5 steps, then frame_start with a step
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'h1B2D);
        cyc(1'b0, 1'b1, 16'hFFFF);
        chk("fs.pm",  64'(pm_a), {32'd0, 8'd32, 8'd32, 8'd32, 8'd0});
        chk("fs.cnt", 64'(sc_a), 64'd0);
        chk("fs.sv",  64'(sv_a), 64'd0);
        cyc(1'b1, 1'b1, 16'h0000);
        chk("fsv.cnt", 64'(sc_a), 64'd1);
        chk("fsv.pm",  64'(pm_a), {32'd0, 8'd32, 8'd0, 8'd32, 8'd0});

        // Valid gaps 1,0,0,1 with hold checks
        cyc(1'b1, 1'b0, 16'h37C1);
        cyc(1'b0, 1'b0, 16'hFFFF);
        cyc(1'b0, 1'b0, 16'h0F0F);
        cyc(1'b1, 1'b0, 16'h2468);

        // Asynchronous reset between back-to-back valid steps
        cyc(1'b1, 1'b0, 16'h5A5A);
        @(negedge clk);
        bm_valid = 1'b1;
        bm_bus   = 16'h9999;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("arst.pm", 64'(pm_a), {32'd0, 8'd32, 8'd32, 8'd32, 8'd0});
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        bm_valid = 1'b0;
        cyc(1'b1, 1'b0, 16'h0000);
        chk("arst.next.pm",  64'(pm_a), {32'd0, 8'd32, 8'd0, 8'd32, 8'd0});
        chk("arst.next.cnt", 64'(sc_a), 64'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
